// File: rtl/shreg_pkg.sv
// rtl/shreg_pkg.sv - mode encodings and fill-count sizing for the universal shift register
package shreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Counter must represent 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shreg_stage.sv
// rtl/shreg_stage.sv - one lane-wide stage register with sync reset and enable
module shreg_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shreg_univ.sv
// rtl/shreg_univ.sv - universal hold/shift/load register with fill tracking; SHREG_ROTATE_EN enables rotate
module shreg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic                   rot,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic                   sout_valid
);

  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic          rot_eff;
  logic          stage_en;
  logic          shifting;
  logic [FW-1:0] fill_cnt;
  logic [FW-1:0] fill_nxt;

`ifdef SHREG_ROTATE_EN
  assign rot_eff = rot;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_eff    = 1'b0;
`endif

  assign stage_en = en && (mode != MODE_HOLD);
  assign shifting = (mode == MODE_SHR) || (mode == MODE_SHL);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] from_r;
    logic [WIDTH-1:0] from_l;
    logic [WIDTH-1:0] d;

    // End stages take the serial input, or the opposite end stage when rotating.
    if (k == 0) begin : g_r_end
      assign from_r = rot_eff ? pout[(DEPTH-1)*WIDTH +: WIDTH] : sin_r;
    end else begin : g_r_mid
      assign from_r = pout[(k-1)*WIDTH +: WIDTH];
    end

    if (k == DEPTH-1) begin : g_l_end
      assign from_l = rot_eff ? pout[0 +: WIDTH] : sin_l;
    end else begin : g_l_mid
      assign from_l = pout[(k+1)*WIDTH +: WIDTH];
    end

    always_comb begin
      d = pout[k*WIDTH +: WIDTH];
      case (mode)
        MODE_SHR:  d = from_r;
        MODE_SHL:  d = from_l;
        MODE_LOAD: d = pin[k*WIDTH +: WIDTH];
        default:   d = pout[k*WIDTH +: WIDTH];
      endcase
    end

    shreg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (stage_en),
      .d   (d),
      .q   (pout[k*WIDTH +: WIDTH])
    );
  end

  assign sout_r = pout[(DEPTH-1)*WIDTH +: WIDTH];
  assign sout_l = pout[0 +: WIDTH];

  // Rotation recirculates existing data, so it adds nothing fresh.
  always_comb begin
    fill_nxt = fill_cnt;
    if (mode == MODE_LOAD) begin
      fill_nxt = FULL;
    end else if (shifting && !rot_eff && fill_cnt != FULL) begin
      fill_nxt = fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt   <= '0;
      sout_valid <= 1'b0;
    end else if (en) begin
      fill_cnt   <= fill_nxt;
      sout_valid <= (fill_nxt == FULL);
    end
  end

endmodule
